alu_issue_arbiter: RTL and testbench
====================================

Name: alu_issue_arbiter

Overview:
- Shares the single 64-bit ALU between NREQ issue requesters (reservation-station slots).
- Round-robin arbitration; one operation in flight at a time.
- Drives the ALU operand/opcode inputs with a start pulse, waits for ALU completion, and broadcasts the tagged result on a common result bus with backpressure.

Parameters:
NREQ, 4, number of requesters (2..8)
TAG_W, 4, width of destination tag carried with each op
WDOG_CYCLES, 64, max EXEC cycles before abort (used only with ALU_ARB_WDOG_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low
req  in  NREQ  per-requester valid; held until granted
req_opcode  in  5*NREQ  packed opcode, slot i at [5i+4:5i]
req_rd_val  in  64*NREQ  packed rd operand
req_rs_val  in  64*NREQ  packed rs operand
req_rt_val  in  64*NREQ  packed rt operand
req_imm  in  12*NREQ  packed immediate
req_tag  in  TAG_W*NREQ  packed destination tag
gnt  out  NREQ  one-hot, one-cycle grant pulse
alu_start  out  1  one-cycle pulse, operands valid
alu_opcode  out  5  held opcode to ALU
alu_rd_val / alu_rs_val / alu_rt_val  out  64 each  held operands
alu_imm  out  12  held immediate
alu_result  in  64  ALU result
alu_done  in  1  ALU completion strobe
cdb_valid  out  1  result broadcast valid
cdb_tag  out  TAG_W  tag of broadcast result
cdb_result  out  64  broadcast value
cdb_illegal  out  1  op was illegal or aborted; result forced to 0
cdb_stall  in  1  consumer backpressure
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset=0): state IDLE, rr pointer 0. All outputs are 0, including alu_* operands, cdb_* and the watchdog flag.
- Legal opcodes: 00000–01101 and 11001–11100. All others are illegal.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - If any req bit is set, select the winner by round-robin, starting the search at the rr pointer.
  - Registered outputs next cycle: gnt[winner]=1 for exactly one cycle. Winner's opcode, operands, imm and tag are latched onto alu_*/internal tag.
  - rr pointer becomes (winner+1) mod NREQ.
  - Legal opcode: alu_start=1 for one cycle, go to EXEC.
  - Illegal opcode: no alu_start, cdb_result=0, cdb_illegal=1, go to WB.
- EXEC:
  - alu_* held stable; alu_start=0.
  - On alu_done=1, capture alu_result into cdb_result, cdb_illegal=0, go to WB.
  - alu_done may arrive in the same cycle as alu_start; it is accepted.
  - alu_done outside EXEC is ignored.
- WB:
  - cdb_valid=1; cdb_tag/result/illegal held stable while cdb_stall=1.
  - In the first cycle with cdb_stall=0, the transfer completes. Next cycle: cdb_valid=0, state IDLE.
  - Arbitration restarts from IDLE; no grant is issued while in WB.
- Minimum latency: req seen in IDLE at cycle N.
  - gnt and alu_start at N+1.
  - alu_done at N+1 gives cdb_valid at N+2.
  - Next grant no earlier than N+4.
- Requesters deasserting req before grant: dropped silently, no state change.
- Simultaneous requests: exactly one grant per arbitration. Fairness: a continuously requesting slot waits at most NREQ-1 other grants.
- Reset mid-operation: the in-flight op is discarded and no broadcast occurs; returns to IDLE.

Optional Feature:
- ALU_ARB_WDOG_EN defined:
  - Adds output wdog_err (1 bit) and an EXEC cycle counter, cleared on entry to EXEC.
  - If the counter reaches WDOG_CYCLES without alu_done: abort to WB with cdb_result=0 and cdb_illegal=1.
  - wdog_err is set and stays sticky until reset.
- ALU_ARB_WDOG_EN undefined: no counter, no wdog_err port; EXEC waits indefinitely.

Test Plan:
- Single req slot 0, ADD, rs=5, rt=7, tag=3; ALU model returns done 1 cycle after start with result 12 -> gnt=0001 one cycle, alu_start one cycle, cdb_valid with tag=3, result=12, illegal=0.
- req=1111 held continuously, ALU done immediately -> grant order 0,1,2,3,0; each gnt one-hot, one cycle.
- Illegal opcode 10000 on slot 2, tag=9 -> gnt=0100, no alu_start, cdb_valid with tag=9, result=0, illegal=1.
- cdb_stall=1 for 5 cycles during WB -> cdb_valid/tag/result stable all 5 cycles; no new gnt until the cycle after stall drops.
- Reset asserted in EXEC -> all outputs 0 immediately; no cdb_valid after reset release; next req granted starting from slot 0.
- With ALU_ARB_WDOG_EN, WDOG_CYCLES=8, ALU never done -> after 8 EXEC cycles cdb_valid with illegal=1, result=0; wdog_err=1 until reset.

Source files
------------

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin issue of NREQ requesters onto one shared 64-bit ALU,
// one op in flight, tagged result broadcast with backpressure. ALU_ARB_WDOG_EN adds an EXEC watchdog.
module alu_issue_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [5*NREQ-1:0]       req_opcode,
  input  logic [64*NREQ-1:0]      req_rd_val,
  input  logic [64*NREQ-1:0]      req_rs_val,
  input  logic [64*NREQ-1:0]      req_rt_val,
  input  logic [12*NREQ-1:0]      req_imm,
  input  logic [TAG_W*NREQ-1:0]   req_tag,
  output logic [NREQ-1:0]         gnt,
  output logic                    alu_start,
  output logic [4:0]              alu_opcode,
  output logic [63:0]             alu_rd_val,
  output logic [63:0]             alu_rs_val,
  output logic [63:0]             alu_rt_val,
  output logic [11:0]             alu_imm,
  input  logic [63:0]             alu_result,
  input  logic                    alu_done,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [63:0]             cdb_result,
  output logic                    cdb_illegal,
  input  logic                    cdb_stall,
`ifdef ALU_ARB_WDOG_EN
  output logic                    wdog_err,
`endif
  output logic                    busy
);

  localparam int unsigned RR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || WDOG_CYCLES == 0) begin : g_param_check
    $error("alu_issue_arbiter: NREQ must be 2..8 and WDOG_CYCLES nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_e;

  state_e             state_q, state_d;
  logic [RR_W-1:0]    rr_q, rr_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               start_q, start_d;
  logic [4:0]         opc_q, opc_d;
  logic [63:0]        rd_q, rd_d;
  logic [63:0]        rs_q, rs_d;
  logic [63:0]        rt_q, rt_d;
  logic [11:0]        imm_q, imm_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [63:0]        res_q, res_d;
  logic               ill_q, ill_d;

  int unsigned        win;
  int unsigned        idx;
  logic               found;

`ifdef ALU_ARB_WDOG_EN
  localparam int unsigned CNT_W = $clog2(WDOG_CYCLES + 1);
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic               werr_q, werr_d;
`endif

  function automatic logic op_is_legal(input logic [4:0] op);
    return (op <= 5'd13) || ((op >= 5'd25) && (op <= 5'd28));
  endfunction

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = '0;
    start_d = 1'b0;
    opc_d   = opc_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    imm_d   = imm_q;
    tag_d   = tag_q;
    res_d   = res_q;
    ill_d   = ill_q;
    win     = 0;
    idx     = 0;
    found   = 1'b0;
`ifdef ALU_ARB_WDOG_EN
    wcnt_d  = wcnt_q;
    werr_d  = werr_q;
`endif

    // Search starts at the rr pointer and wraps, so the first hit is the round-robin winner.
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d[win] = 1'b1;
          rr_d       = (win == NREQ - 1) ? '0 : RR_W'(win + 1);
          opc_d      = req_opcode[5*win +: 5];
          rd_d       = req_rd_val[64*win +: 64];
          rs_d       = req_rs_val[64*win +: 64];
          rt_d       = req_rt_val[64*win +: 64];
          imm_d      = req_imm[12*win +: 12];
          tag_d      = req_tag[TAG_W*win +: TAG_W];
          if (op_is_legal(req_opcode[5*win +: 5])) begin
            start_d = 1'b1;
            state_d = S_EXEC;
`ifdef ALU_ARB_WDOG_EN
            wcnt_d  = '0;
`endif
          end else begin
            res_d   = '0;
            ill_d   = 1'b1;
            state_d = S_WB;
          end
        end
      end
      S_EXEC: begin
        if (alu_done) begin
          res_d   = alu_result;
          ill_d   = 1'b0;
          state_d = S_WB;
        end
`ifdef ALU_ARB_WDOG_EN
        else if (wcnt_q == CNT_W'(WDOG_CYCLES - 1)) begin
          res_d   = '0;
          ill_d   = 1'b1;
          werr_d  = 1'b1;
          state_d = S_WB;
        end else begin
          wcnt_d  = wcnt_q + CNT_W'(1);
        end
`endif
      end
      S_WB: begin
        if (!cdb_stall) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      start_q <= 1'b0;
      opc_q   <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      ill_q   <= 1'b0;
`ifdef ALU_ARB_WDOG_EN
      wcnt_q  <= '0;
      werr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      start_q <= start_d;
      opc_q   <= opc_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      imm_q   <= imm_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
`ifdef ALU_ARB_WDOG_EN
      wcnt_q  <= wcnt_d;
      werr_q  <= werr_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign alu_start   = start_q;
  assign alu_opcode  = opc_q;
  assign alu_rd_val  = rd_q;
  assign alu_rs_val  = rs_q;
  assign alu_rt_val  = rt_q;
  assign alu_imm     = imm_q;
  assign cdb_valid   = (state_q == S_WB);
  assign cdb_tag     = tag_q;
  assign cdb_result  = res_q;
  assign cdb_illegal = ill_q;
  assign busy        = (state_q != S_IDLE);
`ifdef ALU_ARB_WDOG_EN
  assign wdog_err    = werr_q;
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: directed scenarios plus randomized traffic against a transaction-level
// reference of the arbiter; build with ALU_ARB_WDOG_EN to include the watchdog scenario.
module tb_alu_issue_arbiter;

  localparam int NREQ  = 4;
  localparam int TAG_W = 4;
  localparam int WDOG  = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [5*NREQ-1:0]     req_opcode;
  logic [64*NREQ-1:0]    req_rd_val;
  logic [64*NREQ-1:0]    req_rs_val;
  logic [64*NREQ-1:0]    req_rt_val;
  logic [12*NREQ-1:0]    req_imm;
  logic [TAG_W*NREQ-1:0] req_tag;
  logic [NREQ-1:0]       gnt;
  logic                  alu_start;
  logic [4:0]            alu_opcode;
  logic [63:0]           alu_rd_val, alu_rs_val, alu_rt_val;
  logic [11:0]           alu_imm;
  logic [63:0]           alu_result;
  logic                  alu_done;
  logic                  cdb_valid;
  logic [TAG_W-1:0]      cdb_tag;
  logic [63:0]           cdb_result;
  logic                  cdb_illegal;
  logic                  cdb_stall;
  logic                  busy;
`ifdef ALU_ARB_WDOG_EN
  logic                  wdog_err;
`endif

  always #5 clk = ~clk;

  alu_issue_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .reset(reset), .req(req), .req_opcode(req_opcode),
    .req_rd_val(req_rd_val), .req_rs_val(req_rs_val), .req_rt_val(req_rt_val),
    .req_imm(req_imm), .req_tag(req_tag), .gnt(gnt), .alu_start(alu_start),
    .alu_opcode(alu_opcode), .alu_rd_val(alu_rd_val), .alu_rs_val(alu_rs_val),
    .alu_rt_val(alu_rt_val), .alu_imm(alu_imm), .alu_result(alu_result),
    .alu_done(alu_done), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_result(cdb_result), .cdb_illegal(cdb_illegal), .cdb_stall(cdb_stall),
`ifdef ALU_ARB_WDOG_EN
    .wdog_err(wdog_err),
`endif
    .busy(busy)
  );

  // Per-slot request contents, packed onto the buses below.
  logic [4:0]        s_opc [NREQ];
  logic [63:0]       s_rd  [NREQ];
  logic [63:0]       s_rs  [NREQ];
  logic [63:0]       s_rt  [NREQ];
  logic [11:0]       s_imm [NREQ];
  logic [TAG_W-1:0]  s_tag [NREQ];

  always_comb begin
    req_opcode = '0;
    req_rd_val = '0;
    req_rs_val = '0;
    req_rt_val = '0;
    req_imm    = '0;
    req_tag    = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_opcode[5*i +: 5]         = s_opc[i];
      req_rd_val[64*i +: 64]       = s_rd[i];
      req_rs_val[64*i +: 64]       = s_rs[i];
      req_rt_val[64*i +: 64]       = s_rt[i];
      req_imm[12*i +: 12]          = s_imm[i];
      req_tag[TAG_W*i +: TAG_W]    = s_tag[i];
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the arbiter owes the outside world, one transaction at a time.
  typedef enum {M_IDLE, M_EXEC, M_WB} mphase_e;
  mphase_e           m_phase;
  int                m_rr;
  int                m_wd;
  logic              m_werr;
  logic [NREQ-1:0]   exp_gnt;
  logic              exp_start;
  logic [4:0]        mo_opc;
  logic [63:0]       mo_rd, mo_rs, mo_rt, m_res;
  logic [11:0]       mo_imm;
  logic [TAG_W-1:0]  m_tag;
  logic              m_ill;

  // Bench ALU/requester behaviour knobs.
  bit  keep_req;
  bit  alu_sum;
  bit  spurious_en;
  int  alu_fix_lat;
  int  alu_timer;
  int  gnt_log[$];

  function automatic bit op_legal(input logic [4:0] op);
    int v;
    v = int'(op);
    return (v <= 13) || (v >= 25 && v <= 28);
  endfunction

  task automatic model_clear();
    m_phase = M_IDLE; m_rr = 0; m_wd = 0; m_werr = 1'b0;
    exp_gnt = '0; exp_start = 1'b0;
    mo_opc = '0; mo_rd = '0; mo_rs = '0; mo_rt = '0; mo_imm = '0;
    m_tag = '0; m_res = '0; m_ill = 1'b0;
  endtask

  task automatic model_edge();
    int w;
    exp_gnt   = '0;
    exp_start = 1'b0;
    case (m_phase)
      M_IDLE: begin
        if (req != '0) begin
          w = -1;
          for (int k = 0; k < NREQ; k++)
            if (w < 0 && req[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
          exp_gnt[w] = 1'b1;
          m_rr   = (w + 1) % NREQ;
          mo_opc = s_opc[w]; mo_rd = s_rd[w]; mo_rs = s_rs[w]; mo_rt = s_rt[w];
          mo_imm = s_imm[w]; m_tag = s_tag[w];
          if (op_legal(mo_opc)) begin
            exp_start = 1'b1; m_phase = M_EXEC; m_wd = 0;
          end else begin
            m_res = '0; m_ill = 1'b1; m_phase = M_WB;
          end
        end
      end
      M_EXEC: begin
        if (alu_done) begin
          m_res = alu_result; m_ill = 1'b0; m_phase = M_WB;
        end
`ifdef ALU_ARB_WDOG_EN
        else begin
          m_wd++;
          if (m_wd >= WDOG) begin
            m_res = '0; m_ill = 1'b1; m_werr = 1'b1; m_phase = M_WB;
          end
        end
`endif
      end
      M_WB: if (!cdb_stall) m_phase = M_IDLE;
      default: m_phase = M_IDLE;
    endcase
  endtask

  task automatic compare();
    check_eq("busy", 64'(busy), 64'(m_phase != M_IDLE));
    check_eq("gnt", 64'(gnt), 64'(exp_gnt));
    check_eq("alu_start", 64'(alu_start), 64'(exp_start));
    check_eq("cdb_valid", 64'(cdb_valid), 64'(m_phase == M_WB));
    check_eq("alu_opcode", 64'(alu_opcode), 64'(mo_opc));
    check_eq("alu_rd_val", alu_rd_val, mo_rd);
    check_eq("alu_rs_val", alu_rs_val, mo_rs);
    check_eq("alu_rt_val", alu_rt_val, mo_rt);
    check_eq("alu_imm", 64'(alu_imm), 64'(mo_imm));
    if (m_phase == M_WB) begin
      check_eq("cdb_tag", 64'(cdb_tag), 64'(m_tag));
      check_eq("cdb_result", cdb_result, m_res);
      check_eq("cdb_illegal", 64'(cdb_illegal), 64'(m_ill));
    end
`ifdef ALU_ARB_WDOG_EN
    check_eq("wdog_err", 64'(wdog_err), 64'(m_werr));
`endif
  endtask

  task automatic set_req(input int i, input logic [4:0] opc, input logic [63:0] rs,
                         input logic [63:0] rt, input logic [TAG_W-1:0] tag);
    s_opc[i] = opc; s_rs[i] = rs; s_rt[i] = rt; s_tag[i] = tag;
    s_rd[i]  = {$urandom, $urandom};
    s_imm[i] = 12'($urandom);
    req[i]   = 1'b1;
  endtask

  task automatic new_req(input int i);
    set_req(i, 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, TAG_W'($urandom));
  endtask

  task automatic alu_respond();
    if (alu_start) begin
      if (alu_fix_lat == -1) alu_timer = $urandom_range(0, 3);
      else if (alu_fix_lat == -2) alu_timer = -1;
      else alu_timer = alu_fix_lat;
    end
    alu_done   = 1'b0;
    alu_result = {$urandom, $urandom};
    if (alu_timer == 0) begin
      alu_done  = 1'b1;
      alu_timer = -1;
      if (alu_sum) alu_result = alu_rs_val + alu_rt_val;
    end else if (alu_timer > 0) begin
      alu_timer--;
    end else if (spurious_en && m_phase != M_EXEC && $urandom_range(0, 7) == 0) begin
      alu_done = 1'b1;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare();
    for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_log.push_back(i);
    for (int i = 0; i < NREQ; i++) begin
      if (exp_gnt[i]) begin
        if (keep_req) new_req(i);
        else req[i] = 1'b0;
      end
    end
    alu_respond();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #2;
    check_eq("rst_gnt", 64'(gnt), 64'd0);
    check_eq("rst_alu_start", 64'(alu_start), 64'd0);
    check_eq("rst_alu_opcode", 64'(alu_opcode), 64'd0);
    check_eq("rst_alu_rd", alu_rd_val, 64'd0);
    check_eq("rst_alu_rs", alu_rs_val, 64'd0);
    check_eq("rst_alu_rt", alu_rt_val, 64'd0);
    check_eq("rst_alu_imm", 64'(alu_imm), 64'd0);
    check_eq("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check_eq("rst_cdb_tag", 64'(cdb_tag), 64'd0);
    check_eq("rst_cdb_result", cdb_result, 64'd0);
    check_eq("rst_cdb_illegal", 64'(cdb_illegal), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
`ifdef ALU_ARB_WDOG_EN
    check_eq("rst_wdog_err", 64'(wdog_err), 64'd0);
`endif
    req = '0; cdb_stall = 1'b0; alu_done = 1'b0; alu_timer = -1; keep_req = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic drain();
    req = '0; cdb_stall = 1'b0; keep_req = 1'b0;
    for (int n = 0; n < 40 && m_phase != M_IDLE; n++) step();
    check_eq("drain_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout bench did not finish");
    $fatal(1);
  end

  initial begin
    int seen, n_gnt, n_start, cyc, stall_gnts;
    logic [TAG_W-1:0] hold_tag;
    logic [63:0]      hold_res;
    int order[5];

    reset = 1'b1; req = '0; cdb_stall = 1'b0; alu_done = 1'b0; alu_result = '0;
    keep_req = 1'b0; alu_sum = 1'b0; spurious_en = 1'b0; alu_fix_lat = -1; alu_timer = -1;
    for (int i = 0; i < NREQ; i++) begin
      s_opc[i] = '0; s_rd[i] = '0; s_rs[i] = '0; s_rt[i] = '0; s_imm[i] = '0; s_tag[i] = '0;
    end
    model_clear();
    #12;
    apply_reset();

    // Single ADD on slot 0, ALU answers one cycle after start.
    alu_fix_lat = 1; alu_sum = 1'b1;
    set_req(0, 5'b00000, 64'd5, 64'd7, 4'd3);
    seen = 0; n_gnt = 0; n_start = 0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (gnt != '0) begin n_gnt++; check_eq("add_gnt", 64'(gnt), 64'b0001); end
      if (alu_start) n_start++;
      if (cdb_valid) begin
        seen++;
        check_eq("add_tag", 64'(cdb_tag), 64'd3);
        check_eq("add_res", cdb_result, 64'd12);
        check_eq("add_ill", 64'(cdb_illegal), 64'd0);
      end
    end
    check_eq("add_gnt_pulses", 64'(n_gnt), 64'd1);
    check_eq("add_start_pulses", 64'(n_start), 64'd1);
    check_eq("add_valid_cycles", 64'(seen), 64'd1);
    alu_sum = 1'b0;
    drain();

    // All four slots held continuously with an immediate ALU: strict rotation from slot 0.
    apply_reset();
    alu_fix_lat = 0; keep_req = 1'b1;
    for (int i = 0; i < NREQ; i++) new_req(i);
    gnt_log.delete();
    repeat (18) step();
    order = '{0, 1, 2, 3, 0};
    check_eq("rr_count_ok", 64'(gnt_log.size() >= 5), 64'd1);
    for (int k = 0; k < 5; k++)
      if (k < gnt_log.size()) check_eq("rr_order", 64'(gnt_log[k]), 64'(order[k]));
    drain();

    // Illegal opcode on slot 2: straight to broadcast with zero result.
    set_req(2, 5'b10000, 64'd1, 64'd2, 4'd9);
    step();
    check_eq("ill_gnt", 64'(gnt), 64'b0100);
    check_eq("ill_start", 64'(alu_start), 64'd0);
    check_eq("ill_valid", 64'(cdb_valid), 64'd1);
    check_eq("ill_tag", 64'(cdb_tag), 64'd9);
    check_eq("ill_res", cdb_result, 64'd0);
    check_eq("ill_flag", 64'(cdb_illegal), 64'd1);
    drain();

    // Backpressure: broadcast held stable, no grants until the stall drops.
    cdb_stall = 1'b1; alu_fix_lat = 0;
    set_req(1, 5'd2, 64'd100, 64'd23, 4'd5);
    for (int n = 0; n < 10 && !cdb_valid; n++) step();
    check_eq("stall_valid", 64'(cdb_valid), 64'd1);
    hold_tag = cdb_tag; hold_res = cdb_result;
    set_req(3, 5'd4, 64'd8, 64'd9, 4'd12);
    stall_gnts = 0;
    repeat (5) begin
      step();
      check_eq("stall_hold_valid", 64'(cdb_valid), 64'd1);
      check_eq("stall_hold_tag", 64'(cdb_tag), 64'(hold_tag));
      check_eq("stall_hold_res", cdb_result, hold_res);
      if (gnt != '0) stall_gnts++;
    end
    check_eq("stall_no_gnt", 64'(stall_gnts), 64'd0);
    cdb_stall = 1'b0;
    step();
    check_eq("stall_release_valid", 64'(cdb_valid), 64'd0);
    check_eq("stall_release_gnt", 64'(gnt), 64'd0);
    step();
    check_eq("stall_next_gnt", 64'(gnt), 64'b1000);
    drain();

    // Reset while EXEC: op discarded, arbitration restarts at slot 0.
    alu_fix_lat = 10;
    set_req(1, 5'd3, 64'd1, 64'd1, 4'd7);
    step();
    step();
    check_eq("exec_busy", 64'(busy), 64'd1);
    apply_reset();
    alu_fix_lat = -1;
    for (int i = 0; i < NREQ; i++) new_req(i);
    step();
    check_eq("post_rst_gnt", 64'(gnt), 64'b0001);
    drain();

    // Randomized traffic with stalls, random ALU latency and stray alu_done pulses.
    spurious_en = 1'b1; alu_fix_lat = -1;
    repeat (1500) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 99) < 25) new_req(i);
        else if (req[i] && $urandom_range(0, 99) < 3) req[i] = 1'b0;
      end
      cdb_stall = ($urandom_range(0, 99) < 35);
    end
    spurious_en = 1'b0;
    drain();

`ifdef ALU_ARB_WDOG_EN
    // ALU never answers: watchdog aborts after WDOG EXEC cycles and latches wdog_err.
    alu_fix_lat = -2;
    set_req(0, 5'd1, 64'd3, 64'd4, 4'd6);
    step();
    cyc = 0;
    while (!cdb_valid && cyc < 20) begin step(); cyc++; end
    check_eq("wdog_exec_cycles", 64'(cyc), 64'(WDOG));
    check_eq("wdog_illegal", 64'(cdb_illegal), 64'd1);
    check_eq("wdog_result", cdb_result, 64'd0);
    check_eq("wdog_err_set", 64'(wdog_err), 64'd1);
    repeat (4) step();
    check_eq("wdog_err_sticky", 64'(wdog_err), 64'd1);
    apply_reset();
    alu_fix_lat = -1;
`else
    cyc = 0;
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
